// File: rtl/agc_gain_ctrl_pkg.sv
// Shared definitions for the AGC gain controller: FSM state encoding and the
// signed width used for the gain + error update arithmetic.
package agc_gain_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MEAS   = 3'd2,
        ST_CALC   = 3'd3,
        ST_UPDATE = 3'd4
    } agc_state_t;

    // Two guard bits above the wider of the gain and the signed error keep the sum exact.
    function automatic int calc_width(input int gain_width, input int pow_width);
        return ((gain_width > pow_width + 1) ? gain_width : pow_width + 1) + 2;
    endfunction

endpackage

// File: rtl/agc_gain_ctrl_step_sat.sv
// Combinational gain step: gain + (err >>> STEP_SHIFT), clamped to [GAIN_MIN, GAIN_MAX].
module agc_gain_ctrl_step_sat
    import agc_gain_ctrl_pkg::*;
#(
    parameter int GAIN_WIDTH = 16,
    parameter int POW_WIDTH  = 16,
    parameter int STEP_SHIFT = 6,
    parameter int GAIN_MIN   = 16,
    parameter int GAIN_MAX   = 65535
) (
    input  logic [GAIN_WIDTH-1:0]    gain,
    input  logic signed [POW_WIDTH:0] err,
    output logic [GAIN_WIDTH-1:0]    gain_next
);

    localparam int W = calc_width(GAIN_WIDTH, POW_WIDTH);
    localparam logic signed [W-1:0] MIN_W = W'(GAIN_MIN);
    localparam logic signed [W-1:0] MAX_W = W'(GAIN_MAX);

    logic signed [W-1:0] err_wide;
    logic signed [W-1:0] err_step;
    logic signed [W-1:0] gain_wide;
    logic signed [W-1:0] sum;

    assign err_wide  = {{(W-POW_WIDTH-1){err[POW_WIDTH]}}, err};
    assign err_step  = err_wide >>> STEP_SHIFT;
    assign gain_wide = {{(W-GAIN_WIDTH){1'b0}}, gain};
    assign sum       = gain_wide + err_step;

    always_comb begin
        gain_next = sum[GAIN_WIDTH-1:0];
        if (sum < MIN_W) begin
            gain_next = GAIN_WIDTH'(GAIN_MIN);
        end else if (sum > MAX_W) begin
            gain_next = GAIN_WIDTH'(GAIN_MAX);
        end
    end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain controller: measures averaged power against a reference,
// steps the gain word, then discards samples while the measurement pipeline settles.
module agc_gain_ctrl
    import agc_gain_ctrl_pkg::*;
#(
    parameter int POW_WIDTH      = 16,
    parameter int GAIN_WIDTH     = 16,
    parameter int GAIN_POINT     = 12,
    parameter int GAIN_INIT      = 1 << GAIN_POINT,
    parameter int GAIN_MIN       = 16,
    parameter int GAIN_MAX       = 65535,
    parameter int STEP_SHIFT     = 6,
    parameter int SETTLE_SAMPLES = 16,
    parameter int LOCK_COUNT     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [POW_WIDTH-1:0]  pow,
    input  logic                  pow_valid,
    input  logic [POW_WIDTH-1:0]  ref_pow,
    input  logic [POW_WIDTH-1:0]  tol,
    output logic [GAIN_WIDTH-1:0] gain,
    output logic                  gain_valid,
    output logic                  locked
);

    localparam int SC_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int LC_W = $clog2(LOCK_COUNT + 1);

    agc_state_t               state_reg, state_next;
    logic [SC_W-1:0]          settle_cnt_reg, settle_cnt_next;
    logic [LC_W-1:0]          lock_cnt_reg, lock_cnt_next;
    logic signed [POW_WIDTH:0] err_reg, err_next;
    logic [POW_WIDTH-1:0]     tol_reg, tol_next;
    logic [GAIN_WIDTH-1:0]    target_reg, target_next;
    logic [GAIN_WIDTH-1:0]    gain_reg, gain_next;
    logic                     gain_valid_reg, gain_valid_next;
    logic                     locked_reg, locked_next;

    logic [GAIN_WIDTH-1:0]    step_gain;
    logic [POW_WIDTH:0]       err_mag;
    logic                     in_band;

    agc_gain_ctrl_step_sat #(
        .GAIN_WIDTH (GAIN_WIDTH),
        .POW_WIDTH  (POW_WIDTH),
        .STEP_SHIFT (STEP_SHIFT),
        .GAIN_MIN   (GAIN_MIN),
        .GAIN_MAX   (GAIN_MAX)
    ) u_step_sat (
        .gain      (gain_reg),
        .err       (err_reg),
        .gain_next (step_gain)
    );

    // One extra magnitude bit so that err = -2^POW_WIDTH negates without overflow.
    assign err_mag = err_reg[POW_WIDTH] ? $unsigned(-err_reg) : $unsigned(err_reg);
    assign in_band = (err_mag <= {1'b0, tol_reg});

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        lock_cnt_next   = lock_cnt_reg;
        err_next        = err_reg;
        tol_next        = tol_reg;
        target_next     = target_reg;
        gain_next       = gain_reg;
        gain_valid_next = 1'b0;
        locked_next     = locked_reg;

        if (!en) begin
            state_next      = ST_IDLE;
            settle_cnt_next = '0;
            lock_cnt_next   = '0;
            locked_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end
                ST_SETTLE: begin
                    if (pow_valid) begin
                        if (settle_cnt_reg == SC_W'(SETTLE_SAMPLES - 1)) begin
                            settle_cnt_next = '0;
                            state_next      = ST_MEAS;
                        end else begin
                            settle_cnt_next = settle_cnt_reg + SC_W'(1);
                        end
                    end
                end
                ST_MEAS: begin
                    if (pow_valid) begin
                        err_next   = $signed({1'b0, ref_pow}) - $signed({1'b0, pow});
                        tol_next   = tol;
                        state_next = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (in_band) begin
                        if (lock_cnt_reg != LC_W'(LOCK_COUNT)) begin
                            lock_cnt_next = lock_cnt_reg + LC_W'(1);
                        end
                        if (lock_cnt_reg >= LC_W'(LOCK_COUNT - 1)) begin
                            locked_next = 1'b1;
                        end
                        state_next = ST_MEAS;
                    end else begin
                        lock_cnt_next = '0;
                        locked_next   = 1'b0;
                        target_next   = step_gain;
                        state_next    = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    gain_next = target_reg;
                    // A clamped, unchanged gain needs no settling: measure again immediately.
                    if (target_reg != gain_reg) begin
                        gain_valid_next = 1'b1;
                        settle_cnt_next = '0;
                        state_next      = ST_SETTLE;
                    end else begin
                        state_next = ST_MEAS;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            lock_cnt_reg   <= '0;
            err_reg        <= '0;
            tol_reg        <= '0;
            target_reg     <= GAIN_WIDTH'(GAIN_INIT);
            gain_reg       <= GAIN_WIDTH'(GAIN_INIT);
            gain_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            err_reg        <= err_next;
            tol_reg        <= tol_next;
            target_reg     <= target_next;
            gain_reg       <= gain_next;
            gain_valid_reg <= gain_valid_next;
            locked_reg     <= locked_next;
        end
    end

    assign gain       = gain_reg;
    assign gain_valid = gain_valid_reg;
    assign locked     = locked_reg;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Self-checking bench for agc_gain_ctrl: two instances (default init and init at GAIN_MAX)
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_agc_gain_ctrl;

    localparam int SETTLE_N = 16;
    localparam int LOCK_N   = 4;
    localparam int SHIFT_DIV = 64;
    localparam int G_MIN    = 16;
    localparam int G_MAX    = 65535;

    localparam int PH_OFF    = 0;
    localparam int PH_SETTLE = 1;
    localparam int PH_LISTEN = 2;
    localparam int PH_JUDGE  = 3;
    localparam int PH_APPLY  = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] pow;
    logic        pv;
    logic [15:0] ref_pow;
    logic [15:0] tol;
    logic [15:0] gain0, gain1;
    logic        gv0, gv1;
    logic        locked0, locked1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    agc_gain_ctrl dut0 (
        .clk(clk), .rst(rst), .en(en), .pow(pow), .pow_valid(pv),
        .ref_pow(ref_pow), .tol(tol),
        .gain(gain0), .gain_valid(gv0), .locked(locked0)
    );

    agc_gain_ctrl #(.GAIN_INIT(65535)) dut1 (
        .clk(clk), .rst(rst), .en(en), .pow(pow), .pow_valid(pv),
        .ref_pow(ref_pow), .tol(tol),
        .gain(gain1), .gain_valid(gv1), .locked(locked1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: phase of the measurement cycle plus pending error/target, advanced once per clock.
    typedef struct packed {
        int gain;
        int gv;
        int locked;
        int phase;
        int left;
        int lockcnt;
        int err;
        int tolv;
        int target;
    } mdl_t;

    mdl_t m0, m1;

    function automatic int floor_div(input int e);
        if (e >= 0) return e / SHIFT_DIV;
        return -((-e + SHIFT_DIV - 1) / SHIFT_DIV);
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int ginit, input bit r, input bit e,
                                   input bit v, input int p, input int rf, input int t);
        mdl_t n;
        int   mag;
        int   s;
        n    = m;
        n.gv = 0;
        if (!r) begin
            n        = '0;
            n.gain   = ginit;
            n.target = ginit;
            n.phase  = PH_OFF;
            return n;
        end
        if (!e) begin
            n.phase   = PH_OFF;
            n.locked  = 0;
            n.lockcnt = 0;
            return n;
        end
        case (m.phase)
            PH_OFF: begin
                n.phase = PH_SETTLE;
                n.left  = SETTLE_N;
            end
            PH_SETTLE: begin
                if (v) begin
                    n.left = m.left - 1;
                    if (n.left == 0) n.phase = PH_LISTEN;
                end
            end
            PH_LISTEN: begin
                if (v) begin
                    n.err   = rf - p;
                    n.tolv  = t;
                    n.phase = PH_JUDGE;
                end
            end
            PH_JUDGE: begin
                mag = (m.err < 0) ? -m.err : m.err;
                if (mag <= m.tolv) begin
                    n.lockcnt = (m.lockcnt < LOCK_N) ? m.lockcnt + 1 : LOCK_N;
                    if (n.lockcnt == LOCK_N) n.locked = 1;
                    n.phase = PH_LISTEN;
                end else begin
                    n.lockcnt = 0;
                    n.locked  = 0;
                    s = m.gain + floor_div(m.err);
                    if (s < G_MIN) s = G_MIN;
                    if (s > G_MAX) s = G_MAX;
                    n.target = s;
                    n.phase  = PH_APPLY;
                end
            end
            default: begin
                n.gv   = (m.target != m.gain) ? 1 : 0;
                n.gain = m.target;
                if (n.gv != 0) begin
                    n.phase = PH_SETTLE;
                    n.left  = SETTLE_N;
                end else begin
                    n.phase = PH_LISTEN;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m0  <= mstep(m0, 4096, rst, en, pv, int'(pow), int'(ref_pow), int'(tol));
        m1  <= mstep(m1, 65535, rst, en, pv, int'(pow), int'(ref_pow), int'(tol));
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("gain0", int'(gain0), m0.gain);
            chk("gv0", int'(gv0), m0.gv);
            chk("locked0", int'(locked0), m0.locked);
            chk("gain1", int'(gain1), m1.gain);
            chk("gv1", int'(gv1), m1.gv);
            chk("locked1", int'(locked1), m1.locked);
            if (m0.gv != 0) $display("cycle %0d: dut0 gain update -> %0d", cyc, m0.gain);
            if (m1.gv != 0) $display("cycle %0d: dut1 gain update -> %0d", cyc, m1.gain);
        end
    end

    // One pulse: returns at the negedge right after the accepting posedge.
    task automatic pulse_one(input int p);
        pow = 16'(p);
        pv  = 1'b1;
        @(negedge clk);
        pv  = 1'b0;
    endtask

    task automatic pulses(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            pulse_one(p);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gain0", int'(gain0), 4096);
        chk("rst_gv0", int'(gv0), 0);
        chk("rst_locked0", int'(locked0), 0);
        chk("rst_gain1", int'(gain1), 65535);
        rst = 1'b1;
    endtask

    initial begin
        int p;
        rst = 1'b0; en = 1'b0; pv = 1'b0; pow = '0; ref_pow = '0; tol = '0;
        @(negedge clk);
        do_reset();

        // Saturation: dut1 at GAIN_MAX cannot rise, stays in measurement without settling.
        ref_pow = 16'd65535; tol = 16'd0; en = 1'b1;
        @(negedge clk);
        pulses(SETTLE_N, 0);
        pulse_one(0);
        @(negedge clk);
        @(negedge clk);
        chk("sat_gain1", int'(gain1), 65535);
        chk("sat_gv1", int'(gv1), 0);
        chk("sat_gain0", int'(gain0), 5119);
        @(negedge clk);
        ref_pow = 16'd1000;
        pulse_one(2000);
        @(negedge clk);
        @(negedge clk);
        chk("sat_next_gain1", int'(gain1), 65519);
        chk("sat_next_gv1", int'(gv1), 1);

        do_reset();

        // Step down: err = -1000 -> -16.
        ref_pow = 16'd1000; tol = 16'd50;
        @(negedge clk);
        pulses(SETTLE_N, 2000);
        pulse_one(2000);
        @(negedge clk);
        chk("step_lat_gain0", int'(gain0), 4096);
        @(negedge clk);
        chk("step_gain0", int'(gain0), 4080);
        chk("step_gv0", int'(gv0), 1);
        @(negedge clk);
        chk("step_gv0_end", int'(gv0), 0);

        // Settle discard: 16 pulses ignored, the 17th measured (err = +1000 -> +15).
        pulses(15, 0);
        chk("settle15_gain0", int'(gain0), 4080);
        pulse_one(0);
        repeat (3) @(negedge clk);
        chk("settle16_gain0", int'(gain0), 4080);
        pulse_one(0);
        @(negedge clk);
        @(negedge clk);
        chk("settle17_gain0", int'(gain0), 4095);

        // Dead band and lock.
        pulses(SETTLE_N, 1030);
        for (int i = 1; i <= LOCK_N; i++) begin
            pulse_one(1030);
            @(negedge clk);
            chk("lock_seq0", int'(locked0), (i == LOCK_N) ? 1 : 0);
            @(negedge clk);
            @(negedge clk);
        end
        chk("band_gain0", int'(gain0), 4095);
        pulse_one(1200);
        @(negedge clk);
        chk("unlock0", int'(locked0), 0);
        @(negedge clk);
        chk("unlock_gain0", int'(gain0), 4091);

        // en dropped while in CALC, then reset during SETTLE.
        pulses(SETTLE_N, 2000);
        pulse_one(2000);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_gain0", int'(gain0), 4091);
        chk("en_off_locked0", int'(locked0), 0);
        @(negedge clk);
        chk("en_off_gain0_b", int'(gain0), 4091);
        chk("en_off_gv0", int'(gv0), 0);
        en = 1'b1;
        @(negedge clk);
        pulses(3, 2000);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_gain0", int'(gain0), 4096);
        rst = 1'b1;

        // Randomized operation against the model.
        for (int k = 0; k < 600; k++) begin
            if (k % 100 == 0) begin
                ref_pow = 16'($urandom_range(200, 65000));
                tol     = 16'($urandom_range(0, 100));
            end
            if ($urandom_range(0, 40) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                en = 1'b1;
            end
            if ($urandom_range(0, 200) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) p = int'($urandom_range(0, 65535));
            else p = int'(ref_pow) + int'($urandom_range(0, 600)) - 300;
            if (p < 0) p = 0;
            if (p > 65535) p = 65535;
            pulse_one(p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
